// File: rtl/ser_word_collector_if.sv
// Serial-to-word collector bus: serial input side, parallel word side
// and status flags grouped into one bundle.
interface ser_word_collector_if #(
  parameter int WIDTH = 16
);
  logic             sdata;
  logic             sen;
  logic             clr;
  logic             ack;
  logic [WIDTH-1:0] word;
  logic             valid;
  logic             overrun;
  logic             busy;

  modport master (
    output sdata, sen, clr, ack,
    input  word, valid, overrun, busy
  );

  modport slave (
    input  sdata, sen, clr, ack,
    output word, valid, overrun, busy
  );
endinterface

// File: rtl/ser_word_collector.sv
// Shifts a strobed MSB-first bit stream into words and hands each finished
// word to a single-entry valid/ack holding buffer, flagging dropped words.
module ser_word_collector #(
  parameter int CNT_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  ser_word_collector_if.slave bus
);
  localparam int WIDTH = 2 ** CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_bitCount;
  logic [WIDTH-1:0] r_shiftReg;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_nextShift;
  logic             w_complete;

  assign w_nextShift = {r_shiftReg[WIDTH-2:0], bus.sdata};
  assign w_complete  = bus.sen && (r_bitCount == CNT_LAST);

  // The holding buffer keeps running independently of the shifter, so an ack
  // and a completion on the same edge hand over the old word and load the new one.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_bitCount <= '0;
      r_shiftReg <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (bus.clr) begin
      r_state    <= IDLE;
      r_bitCount <= '0;
      r_shiftReg <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_valid && bus.ack) begin
        r_valid <= 1'b0;
      end
      if (bus.sen) begin
        r_shiftReg <= w_nextShift;
        r_bitCount <= r_bitCount + CNT_ONE;
        case (r_state)
          IDLE:    r_state <= SHIFT;
          SHIFT:   if (w_complete) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
      if (w_complete) begin
        if (!r_valid || bus.ack) begin
          r_word  <= w_nextShift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign bus.word    = r_word;
  assign bus.valid   = r_valid;
  assign bus.overrun = r_overrun;
  assign bus.busy    = (r_state == SHIFT);
endmodule

// File: tb/tb_ser_word_collector.sv
// Directed bench for ser_word_collector: reset, basic words, strobe gaps,
// overrun, clear and back-to-back delivery against hand-computed values.
module tb_ser_word_collector;
  logic clk;
  logic rstn;
  int   nChecks;
  int   nPass;

  ser_word_collector_if #(.WIDTH(16)) bus ();

  ser_word_collector #(.CNT_W(4)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic sdata, input logic sen,
                               input logic ack, input logic clr);
    bus.sdata = sdata;
    bus.sen   = sen;
    bus.ack   = ack;
    bus.clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed 0x%04h expected 0x%04h", tag, observed, expected);
  endtask

  // MSB first; ack (if requested) is held only on the completing edge
  task automatic sendBits(input logic [15:0] w, input int nBits, input logic ackLast);
    for (int i = 15; i > 15 - nBits; i--) begin
      applyStimulus(w[i], 1'b1, ackLast && (i == 16 - nBits), 1'b0);
    end
  endtask

  initial begin
    logic [15:0] pattern;
    logic [15:0] b2b [4];
    nChecks   = 0;
    nPass     = 0;
    rstn      = 1'b0;
    bus.sdata = 1'b0;
    bus.sen   = 1'b0;
    bus.ack   = 1'b0;
    bus.clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_word",    bus.word,    16'h0000);
    checkOutput("reset_valid",   bus.valid,   16'h0);
    checkOutput("reset_overrun", bus.overrun, 16'h0);
    checkOutput("reset_busy",    bus.busy,    16'h0);
    rstn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // build up word, valid, overrun and a partial word before async reset
    sendBits(16'h1111, 16, 1'b0);
    sendBits(16'h2222, 16, 1'b0);
    checkOutput("pre_reset_word",    bus.word,    16'h1111);
    checkOutput("pre_reset_overrun", bus.overrun, 16'h1);
    sendBits(16'hFFFF, 7, 1'b0);
    checkOutput("pre_reset_busy", bus.busy, 16'h1);
    bus.sen = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checkOutput("async_word",    bus.word,    16'h0000);
    checkOutput("async_valid",   bus.valid,   16'h0);
    checkOutput("async_overrun", bus.overrun, 16'h0);
    checkOutput("async_busy",    bus.busy,    16'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    sendBits(16'h1234, 16, 1'b0);
    checkOutput("post_reset_word",  bus.word,  16'h1234);
    checkOutput("post_reset_valid", bus.valid, 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("post_reset_ack_valid", bus.valid, 16'h0);

    // basic word
    pattern = 16'hA5C3;
    sendBits(pattern, 1, 1'b0);
    checkOutput("basic_busy_first", bus.busy,  16'h1);
    checkOutput("basic_valid_first", bus.valid, 16'h0);
    for (int i = 14; i >= 1; i--) applyStimulus(pattern[i], 1'b1, 1'b0, 1'b0);
    checkOutput("basic_valid_15", bus.valid, 16'h0);
    applyStimulus(pattern[0], 1'b1, 1'b0, 1'b0);
    checkOutput("basic_valid", bus.valid, 16'h1);
    checkOutput("basic_word",  bus.word,  16'hA5C3);
    checkOutput("basic_busy",  bus.busy,  16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("basic_ack_valid", bus.valid, 16'h0);
    checkOutput("basic_ack_word",  bus.word,  16'hA5C3);

    // strobe gaps with garbage on sdata between strobes
    pattern = 16'h1234;
    for (int i = 15; i >= 1; i--) begin
      applyStimulus(pattern[i], 1'b1, 1'b0, 1'b0);
      applyStimulus(1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    checkOutput("gap_valid_15", bus.valid, 16'h0);
    checkOutput("gap_busy_15",  bus.busy,  16'h1);
    applyStimulus(pattern[0], 1'b1, 1'b0, 1'b0);
    checkOutput("gap_valid", bus.valid, 16'h1);
    checkOutput("gap_word",  bus.word,  16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // overrun: second word completes while the first is still held
    sendBits(16'h1111, 16, 1'b0);
    sendBits(16'hBEEF, 16, 1'b0);
    checkOutput("ovr_word",    bus.word,    16'h1111);
    checkOutput("ovr_valid",   bus.valid,   16'h1);
    checkOutput("ovr_overrun", bus.overrun, 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_sticky", bus.overrun, 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_overrun", bus.overrun, 16'h0);
    checkOutput("clr_word",    bus.word,    16'h0000);
    sendBits(16'h1111, 16, 1'b0);
    sendBits(16'hBEEF, 16, 1'b1);
    checkOutput("simul_word",    bus.word,    16'hBEEF);
    checkOutput("simul_valid",   bus.valid,   16'h1);
    checkOutput("simul_overrun", bus.overrun, 16'h0);

    // clear mid-word overrides sen and the held word
    sendBits(16'hFFFF, 7, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("midclr_busy",    bus.busy,    16'h0);
    checkOutput("midclr_valid",   bus.valid,   16'h0);
    checkOutput("midclr_overrun", bus.overrun, 16'h0);
    checkOutput("midclr_word",    bus.word,    16'h0000);
    sendBits(16'h0F0F, 15, 1'b0);
    checkOutput("midclr_valid_15", bus.valid, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("midclr_new_word",  bus.word,  16'h0F0F);
    checkOutput("midclr_new_valid", bus.valid, 16'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

    // back-to-back, acking each word on the next word's first bit
    b2b[0] = 16'h0001;
    b2b[1] = 16'h8000;
    b2b[2] = 16'hFFFF;
    b2b[3] = 16'h0000;
    for (int w = 0; w < 4; w++) begin
      pattern = b2b[w];
      for (int i = 15; i >= 0; i--) begin
        applyStimulus(pattern[i], 1'b1, (i == 15) && (w > 0), 1'b0);
        if ((i == 15) && (w > 0)) checkOutput("b2b_ack_valid", bus.valid, 16'h0);
      end
      checkOutput("b2b_word",  bus.word,  b2b[w]);
      checkOutput("b2b_valid", bus.valid, 16'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("b2b_final_valid", bus.valid,   16'h0);
    checkOutput("b2b_overrun",     bus.overrun, 16'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
